dac8734_spi_capture: RTL and testbench

//   Synthesizable SPI responder for the DAC8734 lanes: snoops the eight CSB/SCLK/SDI

---
 rtl/dac8734_spi_capture_if.sv | 25 ++
 rtl/dac8734_spi_capture.sv | 184 ++++++++++++++++++
 tb/tb_dac8734_spi_capture.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac8734_spi_capture_if.sv
// Decoded-frame handshake bus between the SPI capture block and its consumer.
// The capture block drives the head-of-queue frame; the consumer answers with ready.
interface dac8734_spi_capture_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  frame_lane;
  logic [7:0]  frame_addr;
  logic [15:0] frame_data;

  modport master (
    output frame_valid,
    output frame_lane,
    output frame_addr,
    output frame_data,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_lane,
    input  frame_addr,
    input  frame_data,
    output frame_ready
  );
endinterface

// File: rtl/dac8734_spi_capture.sv
// Snoops the eight DAC8734 SPI lanes, rebuilds 24-bit frames and queues
// {lane, address, data} words in a fall-through FIFO with sticky error flags.
module dac8734_spi_capture #(
  parameter int NUM_LANES   = 8,
  parameter int FRAME_BITS  = 24,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_LANES-1:0]  spi_csb,
  input  logic [NUM_LANES-1:0]  spi_sclk,
  input  logic [NUM_LANES-1:0]  spi_sdi,
  dac8734_spi_capture_if.master fbus,
  output logic [15:0]           frame_count,
  output logic                  err_len,
  output logic                  err_multi_cs,
  output logic                  err_overflow,
  input  logic                  err_clear
);

  localparam int LANE_W  = $clog2(NUM_LANES);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = LANE_W + FRAME_BITS;
  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN} state_t;

  logic [NUM_LANES-1:0] csb_sync  [SYNC_STAGES];
  logic [NUM_LANES-1:0] sclk_sync [SYNC_STAGES];
  logic [NUM_LANES-1:0] sdi_sync  [SYNC_STAGES];
  logic [NUM_LANES-1:0] csb_d, sclk_d;
  logic [NUM_LANES-1:0] csb_s, sclk_s, sdi_s;
  logic [NUM_LANES-1:0] csb_fall, lane_mask;

  state_t              state, state_n;
  logic [LANE_W-1:0]   lane_q, lane_n, fall_idx;
  logic [4:0]          bit_cnt, cnt_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic                sclk_fall, multi_low;
  logic                push, set_len, set_multi, set_ovf;

  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0]  head;
  logic                full, empty, valid, pop, wr_en;

  // Synchronizers are preset to the idle bus level so reset never looks like a CSB fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        csb_sync[i]  <= '1;
        sclk_sync[i] <= '0;
        sdi_sync[i]  <= '0;
      end
      csb_d  <= '1;
      sclk_d <= '0;
    end else begin
      csb_sync[0]  <= spi_csb;
      sclk_sync[0] <= spi_sclk;
      sdi_sync[0]  <= spi_sdi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        csb_sync[i]  <= csb_sync[i-1];
        sclk_sync[i] <= sclk_sync[i-1];
        sdi_sync[i]  <= sdi_sync[i-1];
      end
      csb_d  <= csb_sync[SYNC_STAGES-1];
      sclk_d <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign csb_fall  = csb_d & ~csb_s;
  assign multi_low = ($countones(~csb_s) > 1);
  assign lane_mask = {{(NUM_LANES-1){1'b0}}, 1'b1} << lane_q;
  assign sclk_fall = sclk_d[lane_q] & ~sclk_s[lane_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      lane_q  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      lane_q  <= lane_n;
      bit_cnt <= cnt_n;
      shreg   <= shreg_n;
    end
  end

  // In SHIFT the SCLK edge is folded in before the CSB rise is judged.
  always_comb begin
    state_n   = state;
    lane_n    = lane_q;
    cnt_n     = bit_cnt;
    shreg_n   = shreg;
    push      = 1'b0;
    set_len   = 1'b0;
    set_multi = 1'b0;
    fall_idx  = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (csb_fall[i]) fall_idx = LANE_W'(i);
    case (state)
      S_IDLE: begin
        if (multi_low) begin
          set_multi = 1'b1;
          state_n   = S_DRAIN;
        end else if (|csb_fall) begin
          state_n = S_SHIFT;
          lane_n  = fall_idx;
          cnt_n   = '0;
          shreg_n = '0;
        end
      end
      S_SHIFT: begin
        if (sclk_fall) begin
          shreg_n = {shreg[FRAME_BITS-2:0], sdi_s[lane_q]};
          if (bit_cnt != 5'd31) cnt_n = bit_cnt + 5'd1;
        end
        if (|(~csb_s & ~lane_mask)) begin
          set_multi = 1'b1;
          state_n   = S_DRAIN;
        end else if (csb_s[lane_q]) begin
          state_n = S_IDLE;
          if (cnt_n == FRAME_CNT) push = 1'b1;
          else                    set_len = 1'b1;
        end
      end
      S_DRAIN: begin
        if (&csb_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign valid = ~empty;
  assign pop   = valid & fbus.frame_ready;
  assign wr_en = push & (~full | pop);
  assign set_ovf = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= {lane_q, shreg_n};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Outputs are gated so the unreset storage never shows through an empty queue.
  assign head             = mem[rd_ptr[PTR_W-1:0]];
  assign fbus.frame_valid = valid;
  assign fbus.frame_lane  = valid ? head[ENTRY_W-1 -: LANE_W] : '0;
  assign fbus.frame_addr  = valid ? head[FRAME_BITS-1 -: 8] : '0;
  assign fbus.frame_data  = valid ? head[15:0] : '0;

  // A flag-setting event beats err_clear in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_len      <= 1'b0;
      err_multi_cs <= 1'b0;
      err_overflow <= 1'b0;
      frame_count  <= '0;
    end else begin
      err_len      <= set_len   | (err_len      & ~err_clear);
      err_multi_cs <= set_multi | (err_multi_cs & ~err_clear);
      err_overflow <= set_ovf   | (err_overflow & ~err_clear);
      if (err_clear)  frame_count <= wr_en ? 16'd1 : 16'd0;
      else if (wr_en) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac8734_spi_capture.sv
// Scoreboard bench for dac8734_spi_capture: drives SPI frames at SCLK=clk/8 and
// compares decoded frames and sticky flags against a queue-based reference model.
module tb_dac8734_spi_capture;

  typedef struct {
    logic [2:0]  lane;
    logic [7:0]  addr;
    logic [15:0] data;
  } frame_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  spi_csb, spi_sclk, spi_sdi;
  logic [15:0] frame_count;
  logic        err_len, err_multi_cs, err_overflow, err_clear;
  logic        ready_ctl = 1'b1;
  bit          rand_ready = 1'b0;

  int          checks = 0;
  int          failures = 0;
  frame_t      exp_q[$];
  int          model_count;
  bit          model_len, model_multi, model_ovf;

  dac8734_spi_capture_if bus();

  dac8734_spi_capture dut (
    .clk          (clk),
    .resetn       (resetn),
    .spi_csb      (spi_csb),
    .spi_sclk     (spi_sclk),
    .spi_sdi      (spi_sdi),
    .fbus         (bus),
    .frame_count  (frame_count),
    .err_len      (err_len),
    .err_multi_cs (err_multi_cs),
    .err_overflow (err_overflow),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bus.frame_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_ctl;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every frame accepted by the consumer is matched in order.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.frame_valid === 1'b1 && bus.frame_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_frame: actual lane=%0d addr=%0h data=%0h expected none",
                 bus.frame_lane, bus.frame_addr, bus.frame_data);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check_output("frame_lane", 32'(bus.frame_lane), 32'(e.lane));
        check_output("frame_addr", 32'(bus.frame_addr), 32'(e.addr));
        check_output("frame_data", 32'(bus.frame_data), 32'(e.data));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input int lane, input logic [23:0] word);
    frame_t f;
    f.lane = 3'(lane);
    f.addr = word[23:16];
    f.data = word[15:0];
    if (exp_q.size() < 16) begin
      exp_q.push_back(f);
      model_count = (model_count + 1) % 65536;
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic send_bits(input int lane, input logic [23:0] word, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      spi_sdi[lane]  = word[23-b];
      spi_sclk[lane] = 1'b1;
      wait_clk(4);
      spi_sclk[lane] = 1'b0;
      wait_clk(4);
    end
  endtask

  // One chip-select transaction of nbits; only a full frame is expected in the queue.
  task automatic apply_stimulus(input int lane, input logic [23:0] word,
                                input int nbits, input bit lat_chk);
    spi_csb[lane] = 1'b0;
    wait_clk(4);
    send_bits(lane, word, nbits);
    wait_clk(4);
    spi_csb[lane] = 1'b1;
    if (nbits == 24) model_push(lane, word);
    else             model_len = 1'b1;
    wait_clk(4);
    if (lat_chk) check_output("latency_valid", 32'(bus.frame_valid), 32'd1);
    wait_clk(6);
  endtask

  task automatic check_flags(input string tag);
    check_output({tag, "_count"},    32'(frame_count),  32'(model_count));
    check_output({tag, "_err_len"},  32'(err_len),      32'(model_len));
    check_output({tag, "_err_multi"},32'(err_multi_cs), 32'(model_multi));
    check_output({tag, "_err_ovf"},  32'(err_overflow), 32'(model_ovf));
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    wait_clk(1);
    err_clear = 1'b0;
    wait_clk(2);
    model_count = 0;
    model_len   = 1'b0;
    model_multi = 1'b0;
    model_ovf   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      wait_clk(1);
      n++;
    end
    check_output({tag, "_pending_frames"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_valid"}, 32'(bus.frame_valid), 32'd0);
    check_output({tag, "_lane"},  32'(bus.frame_lane),  32'd0);
    check_output({tag, "_addr"},  32'(bus.frame_addr),  32'd0);
    check_output({tag, "_data"},  32'(bus.frame_data),  32'd0);
    check_flags(tag);
  endtask

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    spi_csb = 8'hFF; spi_sclk = 8'h00; spi_sdi = 8'h00; err_clear = 1'b0;
    model_count = 0; model_len = 0; model_multi = 0; model_ovf = 0;
    wait_clk(5);
    check_reset_outputs("reset");
    resetn = 1'b1;
    wait_clk(5);

    apply_stimulus(0, 24'h041999, 24, 1'b0);
    check_flags("lane0");
    for (int l = 1; l < 8; l++) apply_stimulus(l, 24'h041999, 24, 1'b0);
    check_flags("lanes1to7");
    wait_drain("lanes");

    apply_stimulus(2, 24'h05ABCD, 23, 1'b0);
    check_flags("short_frame");
    apply_stimulus(2, 24'h061234, 24, 1'b0);
    check_flags("after_short");

    spi_csb[3] = 1'b0; spi_csb[5] = 1'b0;
    wait_clk(4);
    send_bits(3, 24'h0F0F0F, 8);
    spi_csb = 8'hFF;
    wait_clk(10);
    model_multi = 1'b1;
    check_flags("multi_idle");
    apply_stimulus(4, 24'h0A8000, 24, 1'b0);
    check_flags("after_multi");
    wait_drain("multi");

    pulse_clear();
    check_flags("cleared");
    spi_csb[1] = 1'b0;
    wait_clk(4);
    send_bits(1, 24'h123456, 5);
    spi_csb[6] = 1'b0;
    wait_clk(8);
    spi_csb = 8'hFF;
    wait_clk(10);
    model_multi = 1'b1;
    check_flags("multi_shift");
    pulse_clear();

    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(int'($urandom_range(0, 7)), 24'($urandom), 24, 1'b0);
      check_flags("random");
    end
    rand_ready = 1'b0;
    ready_ctl  = 1'b1;
    wait_drain("random");

    ready_ctl = 1'b0;
    pulse_clear();
    for (int i = 0; i < 17; i++)
      apply_stimulus(int'($urandom_range(0, 7)), 24'($urandom), 24, i == 0);
    check_flags("overflow");
    ready_ctl = 1'b1;
    wait_drain("overflow");

    ready_ctl = 1'b0;
    apply_stimulus(6, 24'h0BCAFE, 24, 1'b1);
    spi_csb[5] = 1'b0;
    wait_clk(4);
    send_bits(5, 24'h0C5555, 11);
    spi_sdi[5]  = 1'b1;
    spi_sclk[5] = 1'b1;
    wait_clk(2);
    resetn = 1'b0;
    exp_q.delete();
    model_count = 0; model_len = 0; model_multi = 0; model_ovf = 0;
    wait_clk(2);
    check_reset_outputs("midframe_reset");
    spi_csb = 8'hFF; spi_sclk = 8'h00; spi_sdi = 8'h00;
    wait_clk(4);
    resetn = 1'b1;
    ready_ctl = 1'b1;
    wait_clk(4);
    apply_stimulus(7, 24'h0D7E57, 24, 1'b0);
    check_flags("post_reset");
    wait_drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
